sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//   Shares the single external 16-bit SRAM between two requesters: the SLC-3 core
//   (MAR/MDR memory cycles) and the debug/loader port (program load, memory peek).
//   Grants one access at a time, sequences the active-low SRAM strobes with a fixed
//   number of wait states and returns a one-cycle Ack to the winner.
//   Sits between slc3 and the SRAM pins in lab6_toplevel. Tristate of Data is done in the toplevel.
// PARAMETERS
//   ADDR_W      20  SRAM address width
//   DATA_W      16  SRAM data width
//   WAIT_CYCLES 2   cycles the strobes are held in ACCESS (legal range 1..15)
// PORTS
//   Clk           in   1       system clock, all logic on rising edge
//   Reset         in   1       synchronous, active-high reset
//   CPU_Req       in   1       core requests an access; held with Addr/WE/WData until CPU_Ack
//   CPU_WE        in   1       1 = write, 0 = read
//   CPU_Addr      in   ADDR_W  core address
//   CPU_WData     in   DATA_W  core write data
//   CPU_RData     out  DATA_W  read data, valid in the CPU_Ack cycle
//   CPU_Ack       out  1       one-cycle completion pulse to the core
//   DBG_Req/DBG_WE/DBG_Addr/DBG_WData/DBG_RData/DBG_Ack   same as the CPU_* set, for the debug port
//   CE,OE,WE,UB,LB out  1      SRAM strobes, active low
//   ADDR          out  ADDR_W  SRAM address
//   Data_Out      out  DATA_W  write data toward SRAM
//   Data_Drive    out  1       1 = toplevel drives Data with Data_Out
//   Data_In       in   DATA_W  Data bus as read from SRAM
//   Busy          out  1       1 whenever state != IDLE
//   Grant_Dbg     out  1       owner of the current access (0 = CPU, 1 = DBG)
// BEHAVIOUR
//   Reset: state=IDLE. CE=OE=WE=UB=LB=1. Data_Drive=0. ADDR=0, Data_Out=0. *_RData=0.
//     *_Ack=0, Busy=0. last_grant=DBG, so the CPU wins the first tie. Grant_Dbg=0.
//     Reset mid-access aborts: strobes go high at that edge and no Ack is issued.
//   FSM: IDLE -> ACCESS -> (write: RECOVER ->) DONE -> IDLE.
//   IDLE: a Req is sampled at the clock edge. Only one Req: that requester is granted.
//     Both Req: the requester other than last_grant is granted (round-robin).
//     On grant: latch Addr/WE/WData and the owner, load cnt=WAIT_CYCLES-1, go to ACCESS.
//     Requester inputs are ignored outside IDLE.
//   ACCESS: CE=UB=LB=0 and ADDR=latched address.
//     Read: OE=0. Write: WE=0, Data_Drive=1.
//     cnt decrements each cycle. At cnt==0: a read captures Data_In into the owner's
//     RData at that edge and goes to DONE; a write goes to RECOVER.
//   RECOVER (write only, 1 cycle): WE=1, CE=0, Data_Drive=1 with the address and data
//     unchanged. This gives data/address hold after the WE rising edge.
//   DONE (1 cycle): all strobes high, Data_Drive=0, owner's Ack=1. last_grant=owner.
//     Always goes to IDLE, and the Req level seen in DONE is ignored.
//     The requester drops Req in the cycle after it sees Ack, or re-arbitrates in IDLE.
//   Latency (Req high at edge 0): read Ack is high in cycle WAIT_CYCLES+1 (3 by default).
//     Write Ack is high in cycle WAIT_CYCLES+2 (4 by default).
//     Back-to-back accesses have one IDLE cycle between DONE and the next ACCESS.
//   RData of the non-owner holds its previous value. Ack is never asserted for both requesters.
//   OE and WE are never low in the same cycle. Data_Drive=1 only in write ACCESS/RECOVER.
// TESTING
//   1 CPU read x0005, SRAM returns x1234, WAIT=2: OE low for 2 cycles, CPU_Ack in cycle 3,
//     CPU_RData=x1234, DBG_Ack stays 0.
//   2 DBG write xBEEF to x0031: WE low for 2 cycles, then 1 RECOVER cycle with WE=1 and
//     Data_Drive=1, DBG_Ack in cycle 4, SRAM model holds xBEEF.
//   3 CPU and DBG Req in the same cycle after reset: CPU served first, DBG Ack 4 cycles
//     after CPU Ack (read/read). With both held, grants alternate CPU, DBG, CPU.
//   4 Reset=1 in the 2nd ACCESS cycle of a write: WE/CE high at the next edge, no Ack,
//     Busy=0. A following read returns the pre-write value.
//   5 DBG reads 16 consecutive addresses x005A..x0069: 16 Acks, each read 4 cycles apart,
//     data matches the model.
//   6 WAIT_CYCLES=1 build: read Ack in cycle 2, write Ack in cycle 3.

Source files
------------

// File: rtl/sram_access_arbiter_if.sv
// ============================================================================
// Module      : sram_access_arbiter_if
// Description : Requester handshakes (CPU and debug) plus SRAM pin bundle
//               for the SRAM access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_access_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              CPU_Req;
    logic              CPU_WE;
    logic [ADDR_W-1:0] CPU_Addr;
    logic [DATA_W-1:0] CPU_WData;
    logic [DATA_W-1:0] CPU_RData;
    logic              CPU_Ack;

    logic              DBG_Req;
    logic              DBG_WE;
    logic [ADDR_W-1:0] DBG_Addr;
    logic [DATA_W-1:0] DBG_WData;
    logic [DATA_W-1:0] DBG_RData;
    logic              DBG_Ack;

    logic              CE, OE, WE, UB, LB;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_Out;
    logic              Data_Drive;
    logic [DATA_W-1:0] Data_In;
    logic              Busy;
    logic              Grant_Dbg;

    modport slave (
        input  CPU_Req, CPU_WE, CPU_Addr, CPU_WData,
        input  DBG_Req, DBG_WE, DBG_Addr, DBG_WData,
        input  Data_In,
        output CPU_RData, CPU_Ack, DBG_RData, DBG_Ack,
        output CE, OE, WE, UB, LB, ADDR, Data_Out, Data_Drive, Busy, Grant_Dbg
    );

    modport master (
        output CPU_Req, CPU_WE, CPU_Addr, CPU_WData,
        output DBG_Req, DBG_WE, DBG_Addr, DBG_WData,
        output Data_In,
        input  CPU_RData, CPU_Ack, DBG_RData, DBG_Ack,
        input  CE, OE, WE, UB, LB, ADDR, Data_Out, Data_Drive, Busy, Grant_Dbg
    );
endinterface

`default_nettype wire

// File: rtl/sram_access_arbiter.sv
// ============================================================================
// Module      : sram_access_arbiter
// Description : Round-robin arbiter sharing one async SRAM between the core
//               and the debug/loader port, with registered active-low strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_access_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2      // legal range 1..15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sram_access_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_owner;
    logic              r_last_dbg;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_cpu_ack;
    logic              r_dbg_ack;
    logic              r_ce;
    logic              r_oe;
    logic              r_we_n;
    logic              r_bl;
    logic              r_drive;
    logic              r_busy;

    logic              w_req_any;
    logic              w_pick_dbg;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // On a tie the debug port wins only if the core was served last.
    assign w_req_any   = bus.CPU_Req | bus.DBG_Req;
    assign w_pick_dbg  = bus.DBG_Req & (~bus.CPU_Req | ~r_last_dbg);
    assign w_sel_we    = w_pick_dbg ? bus.DBG_WE    : bus.CPU_WE;
    assign w_sel_addr  = w_pick_dbg ? bus.DBG_Addr  : bus.CPU_Addr;
    assign w_sel_wdata = w_pick_dbg ? bus.DBG_WData : bus.CPU_WData;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_last_dbg  <= 1'b1;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_ce        <= 1'b1;
            r_oe        <= 1'b1;
            r_we_n      <= 1'b1;
            r_bl        <= 1'b1;
            r_drive     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner <= w_pick_dbg;
                        r_wr    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= S_ACCESS;
                        r_busy  <= 1'b1;
                        r_ce    <= 1'b0;
                        r_bl    <= 1'b0;
                        r_oe    <= w_sel_we;
                        r_we_n  <= ~w_sel_we;
                        r_drive <= w_sel_we;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (r_wr) begin
                            // Raise WE only; CE, address and data hold one more cycle.
                            r_we_n  <= 1'b1;
                            r_state <= S_RECOVER;
                        end else begin
                            if (r_owner) begin
                                r_dbg_rdata <= bus.Data_In;
                            end else begin
                                r_cpu_rdata <= bus.Data_In;
                            end
                            r_dbg_ack <= r_owner;
                            r_cpu_ack <= ~r_owner;
                            r_ce      <= 1'b1;
                            r_oe      <= 1'b1;
                            r_bl      <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RECOVER: begin
                    r_dbg_ack <= r_owner;
                    r_cpu_ack <= ~r_owner;
                    r_ce      <= 1'b1;
                    r_bl      <= 1'b1;
                    r_drive   <= 1'b0;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_last_dbg <= r_owner;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.CE         = r_ce;
    assign bus.OE         = r_oe;
    assign bus.WE         = r_we_n;
    assign bus.UB         = r_bl;
    assign bus.LB         = r_bl;
    assign bus.ADDR       = r_addr;
    assign bus.Data_Out   = r_wdata;
    assign bus.Data_Drive = r_drive;
    assign bus.CPU_RData  = r_cpu_rdata;
    assign bus.DBG_RData  = r_dbg_rdata;
    assign bus.CPU_Ack    = r_cpu_ack;
    assign bus.DBG_Ack    = r_dbg_ack;
    assign bus.Busy       = r_busy;
    assign bus.Grant_Dbg  = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
// ============================================================================
// Module      : tb_sram_access_arbiter
// Description : Directed self-checking bench with an async SRAM model; covers
//               the default build and a WAIT_CYCLES=1 build.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_access_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );
    sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
        .Clk(clk), .Reset(rst), .bus(bus1)
    );

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return (a == 8'h05) ? 16'h1234 : {a ^ 8'h3C, ~a};
    endfunction

    // SRAM models: a write commits on the WE rising edge only while CE stays low.
    logic [DW-1:0] mem  [0:255];
    logic [DW-1:0] mem1 [0:255];
    logic          filled = 1'b0;
    logic          pend = 1'b0, pend1 = 1'b0;
    logic [7:0]    paddr, paddr1;
    logic [DW-1:0] pdata, pdata1;

    assign bus.Data_In  = (!bus.CE  && !bus.OE)  ? mem[bus.ADDR[7:0]]   : 16'hDEAD;
    assign bus1.Data_In = (!bus1.CE && !bus1.OE) ? mem1[bus1.ADDR[7:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= init_word(8'(i));
                mem1[i] <= init_word(8'(i));
            end
            filled <= 1'b1;
        end
        if (!bus.CE && !bus.WE) begin
            pend <= 1'b1; paddr <= bus.ADDR[7:0]; pdata <= bus.Data_Out;
        end else begin
            if (pend && !bus.CE) mem[paddr] <= pdata;
            pend <= 1'b0;
        end
        if (!bus1.CE && !bus1.WE) begin
            pend1 <= 1'b1; paddr1 <= bus1.ADDR[7:0]; pdata1 <= bus1.Data_Out;
        end else begin
            if (pend1 && !bus1.CE) mem1[paddr1] <= pdata1;
            pend1 <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.CE, bus.OE, bus.WE, bus.UB, bus.LB, bus.Data_Drive, bus.Busy,
             bus.Grant_Dbg, bus.CPU_Ack, bus.DBG_Ack} !== 10'b1111100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", {bus.CE, bus.OE, bus.WE, bus.UB, bus.LB,
                     bus.Data_Drive, bus.Busy, bus.Grant_Dbg, bus.CPU_Ack, bus.DBG_Ack}, 10'b1111100000);
        end
        checks++;
        if ({bus.ADDR, bus.Data_Out, bus.CPU_RData, bus.DBG_RData} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h dout %h crd %h drd %h expected all zero",
                     bus.ADDR, bus.Data_Out, bus.CPU_RData, bus.DBG_RData);
        end
        checks++;
        if ({bus1.CE, bus1.OE, bus1.WE, bus1.Data_Drive, bus1.Busy} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_w1: got %b expected 11100",
                     {bus1.CE, bus1.OE, bus1.WE, bus1.Data_Drive, bus1.Busy});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        bus.CPU_Addr = 20'h00005; bus.CPU_WE = 1'b0; bus.CPU_Req = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if ({bus.CE, bus.OE, bus.WE, bus.Data_Drive, bus.CPU_Ack, bus.DBG_Ack, bus.Busy} !== 7'b0010001
                || bus.ADDR !== 20'h00005) begin
                errors++;
                $display("FAIL cpu_read_access c%0d: ctrl %b addr %h expected 0010001 addr 00005", c,
                         {bus.CE, bus.OE, bus.WE, bus.Data_Drive, bus.CPU_Ack, bus.DBG_Ack, bus.Busy}, bus.ADDR);
            end
        end
        tick();
        checks++;
        if ({bus.CPU_Ack, bus.DBG_Ack, bus.CE, bus.OE, bus.WE, bus.Busy} !== 6'b101111) begin
            errors++;
            $display("FAIL cpu_read_ack: got %b expected 101111",
                     {bus.CPU_Ack, bus.DBG_Ack, bus.CE, bus.OE, bus.WE, bus.Busy});
        end
        checks++;
        if (bus.CPU_RData !== 16'h1234) begin
            errors++;
            $display("FAIL cpu_read_data: got %h expected 1234", bus.CPU_RData);
        end
        bus.CPU_Req = 1'b0;
        tick();
        checks++;
        if ({bus.Busy, bus.CPU_Ack} !== 2'b00) begin
            errors++;
            $display("FAIL cpu_read_idle: busy/ack %b expected 00", {bus.Busy, bus.CPU_Ack});
        end
    endtask

    task automatic test_dbg_write();
        bus.DBG_Addr = 20'h00031; bus.DBG_WData = 16'hBEEF; bus.DBG_WE = 1'b1; bus.DBG_Req = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if ({bus.CE, bus.OE, bus.WE, bus.Data_Drive, bus.Busy, bus.Grant_Dbg, bus.DBG_Ack} !== 7'b0101110
                || bus.Data_Out !== 16'hBEEF || bus.ADDR !== 20'h00031) begin
                errors++;
                $display("FAIL dbg_write_access c%0d: ctrl %b dout %h addr %h expected 0101110 beef 00031", c,
                         {bus.CE, bus.OE, bus.WE, bus.Data_Drive, bus.Busy, bus.Grant_Dbg, bus.DBG_Ack},
                         bus.Data_Out, bus.ADDR);
            end
        end
        tick();
        checks++;
        if ({bus.CE, bus.OE, bus.WE, bus.Data_Drive, bus.DBG_Ack} !== 5'b01110
            || bus.Data_Out !== 16'hBEEF || bus.ADDR !== 20'h00031) begin
            errors++;
            $display("FAIL dbg_write_recover: ctrl %b dout %h addr %h expected 01110 beef 00031",
                     {bus.CE, bus.OE, bus.WE, bus.Data_Drive, bus.DBG_Ack}, bus.Data_Out, bus.ADDR);
        end
        tick();
        checks++;
        if ({bus.DBG_Ack, bus.CPU_Ack, bus.CE, bus.WE, bus.Data_Drive} !== 5'b10110) begin
            errors++;
            $display("FAIL dbg_write_ack: got %b expected 10110",
                     {bus.DBG_Ack, bus.CPU_Ack, bus.CE, bus.WE, bus.Data_Drive});
        end
        checks++;
        if (mem[8'h31] !== 16'hBEEF) begin
            errors++;
            $display("FAIL dbg_write_mem: got %h expected beef", mem[8'h31]);
        end
        bus.DBG_Req = 1'b0; bus.DBG_WE = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        bus.CPU_Addr = 20'h00010; bus.CPU_WE = 1'b0;
        bus.DBG_Addr = 20'h00020; bus.DBG_WE = 1'b0;
        bus.CPU_Req = 1'b1; bus.DBG_Req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            checks++;
            if (bus.CPU_Ack !== (c == 3 || c == 11) || bus.DBG_Ack !== (c == 7)) begin
                errors++;
                $display("FAIL rr_ack c%0d: cpu %b dbg %b expected %b %b", c, bus.CPU_Ack, bus.DBG_Ack,
                         (c == 3 || c == 11), (c == 7));
            end
            if (c == 1 || c == 5 || c == 9) begin
                checks++;
                if (bus.Grant_Dbg !== (c == 5)) begin
                    errors++;
                    $display("FAIL rr_grant c%0d: got %b expected %b", c, bus.Grant_Dbg, (c == 5));
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.DBG_RData !== init_word(8'h20) || bus.CPU_RData !== init_word(8'h10)) begin
                    errors++;
                    $display("FAIL rr_data: dbg %h cpu %h expected %h %h", bus.DBG_RData, bus.CPU_RData,
                             init_word(8'h20), init_word(8'h10));
                end
            end
        end
        bus.CPU_Req = 1'b0; bus.DBG_Req = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        bus.CPU_Addr = 20'h00040; bus.CPU_WData = 16'hAAAA; bus.CPU_WE = 1'b1; bus.CPU_Req = 1'b1;
        tick(); tick();
        checks++;
        if ({bus.CE, bus.WE} !== 2'b00) begin
            errors++;
            $display("FAIL abort_pre: ce/we %b expected 00", {bus.CE, bus.WE});
        end
        rst = 1'b1; bus.CPU_Req = 1'b0; bus.CPU_WE = 1'b0;
        tick();
        checks++;
        if ({bus.CE, bus.WE, bus.Busy, bus.CPU_Ack, bus.Data_Drive} !== 5'b11000) begin
            errors++;
            $display("FAIL abort_strobes: got %b expected 11000",
                     {bus.CE, bus.WE, bus.Busy, bus.CPU_Ack, bus.Data_Drive});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.CPU_Ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_noack: got %b expected 0", bus.CPU_Ack);
        end
        bus.CPU_Req = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.CPU_Ack !== 1'b1 || bus.CPU_RData !== init_word(8'h40)) begin
            errors++;
            $display("FAIL abort_readback: ack %b data %h expected 1 %h", bus.CPU_Ack, bus.CPU_RData,
                     init_word(8'h40));
        end
        bus.CPU_Req = 1'b0;
        tick();
    endtask

    task automatic test_dbg_burst();
        int n = 0;
        int last_c = 0;
        bus.DBG_Addr = 20'h0005A; bus.DBG_WE = 1'b0; bus.DBG_Req = 1'b1;
        for (int c = 1; c <= 80 && n < 16; c++) begin
            tick();
            checks++;
            if ((!bus.OE && !bus.WE) || bus.Data_Drive || bus.CPU_Ack) begin
                errors++;
                $display("FAIL burst_ctrl c%0d: oe %b we %b drive %b cpu_ack %b expected no overlap, no drive, no cpu ack",
                         c, bus.OE, bus.WE, bus.Data_Drive, bus.CPU_Ack);
            end
            if (bus.DBG_Ack) begin
                checks++;
                if (bus.DBG_RData !== init_word(8'(8'h5A + n)) || (c - last_c) != ((n == 0) ? 3 : 4)) begin
                    errors++;
                    $display("FAIL burst_read %0d: data %h gap %0d expected %h gap %0d", n, bus.DBG_RData,
                             c - last_c, init_word(8'(8'h5A + n)), (n == 0) ? 3 : 4);
                end
                n++;
                last_c = c;
                if (n < 16) bus.DBG_Addr = 20'(20'h0005A + n);
                else        bus.DBG_Req = 1'b0;
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL burst_count: got %0d acks expected 16", n);
            bus.DBG_Req = 1'b0;
        end
        tick();
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_idle: busy %b expected 0", bus.Busy);
        end
    endtask

    task automatic test_wait1();
        bus1.CPU_Addr = 20'h00005; bus1.CPU_WE = 1'b0; bus1.CPU_Req = 1'b1;
        tick();
        checks++;
        if ({bus1.OE, bus1.CPU_Ack} !== 2'b00) begin
            errors++;
            $display("FAIL w1_read_c1: oe/ack %b expected 00", {bus1.OE, bus1.CPU_Ack});
        end
        tick();
        checks++;
        if (bus1.CPU_Ack !== 1'b1 || bus1.CPU_RData !== 16'h1234) begin
            errors++;
            $display("FAIL w1_read_ack: ack %b data %h expected 1 1234", bus1.CPU_Ack, bus1.CPU_RData);
        end
        bus1.CPU_Req = 1'b0;
        tick();
        bus1.DBG_Addr = 20'h00077; bus1.DBG_WData = 16'h5A5A; bus1.DBG_WE = 1'b1; bus1.DBG_Req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (bus1.DBG_Ack !== (c == 3) || bus1.WE !== (c != 1)) begin
                errors++;
                $display("FAIL w1_write c%0d: ack %b we %b expected %b %b", c, bus1.DBG_Ack, bus1.WE,
                         (c == 3), (c != 1));
            end
        end
        bus1.DBG_Req = 1'b0; bus1.DBG_WE = 1'b0;
        tick();
        bus1.DBG_Req = 1'b1;
        tick(); tick();
        checks++;
        if (bus1.DBG_Ack !== 1'b1 || bus1.DBG_RData !== 16'h5A5A || mem1[8'h77] !== 16'h5A5A) begin
            errors++;
            $display("FAIL w1_readback: ack %b data %h mem %h expected 1 5a5a 5a5a", bus1.DBG_Ack,
                     bus1.DBG_RData, mem1[8'h77]);
        end
        bus1.DBG_Req = 1'b0;
        tick();
    endtask

    initial begin
        bus.CPU_Req = 1'b0;  bus.CPU_WE = 1'b0;  bus.CPU_Addr = '0;  bus.CPU_WData = '0;
        bus.DBG_Req = 1'b0;  bus.DBG_WE = 1'b0;  bus.DBG_Addr = '0;  bus.DBG_WData = '0;
        bus1.CPU_Req = 1'b0; bus1.CPU_WE = 1'b0; bus1.CPU_Addr = '0; bus1.CPU_WData = '0;
        bus1.DBG_Req = 1'b0; bus1.DBG_WE = 1'b0; bus1.DBG_Addr = '0; bus1.DBG_WData = '0;
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_round_robin();
        test_reset_abort();
        test_dbg_burst();
        test_wait1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
